rot_sched: RTL and testbench

//  Shares the single mux -> rotator -> demux datapath among NREQ requesters.

---
 rtl/rot_sched_pkg.sv | 23 ++
 rtl/rot_sched_if.sv | 39 +++
 rtl/rot_sched_rr_arbiter.sv | 37 +++
 rtl/rot_sched.sv | 137 +++++++++++++
 tb/tb_rot_sched.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rot_sched_pkg.sv
// Shared types and constants for the rotator resource scheduler.
//  state_t : 2-bit scheduler state encoding
//  *_DEF   : default parameter values
//  idx_w() : index width for an N-entry select (minimum 1 bit)
package rot_sched_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned RW_DEF   = 3;
    localparam int unsigned LAT_DEF  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    // Select width for n entries; a 1-entry select still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rot_sched_if.sv
// Requester/datapath-control bundle of the rotator scheduler.
//  req, rot_amt        : requester side -> scheduler
//  gnt                 : one-hot grant pulse back to requesters
//  mux_sel, rotation,
//  issue_valid         : datapath input control
//  demux_sel,
//  demux_valid         : datapath output steering
//  busy                : scheduler not idle
// master = requesters/datapath side, slave = scheduler.
interface rot_sched_if
    import rot_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned RW   = RW_DEF
) ();

    localparam int unsigned IDXW = idx_w(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*RW-1:0] rot_amt;
    logic [NREQ-1:0]    gnt;
    logic [IDXW-1:0]    mux_sel;
    logic [RW-1:0]      rotation;
    logic               issue_valid;
    logic [IDXW-1:0]    demux_sel;
    logic               demux_valid;
    logic               busy;

    modport master (
        output req, rot_amt,
        input  gnt, mux_sel, rotation, issue_valid, demux_sel, demux_valid, busy
    );

    modport slave (
        input  req, rot_amt,
        output gnt, mux_sel, rotation, issue_valid, demux_sel, demux_valid, busy
    );

endinterface

// File: rtl/rot_sched_rr_arbiter.sv
// Combinational round-robin pick.
//  i_req   : request vector
//  i_ptr   : highest-priority index this round
//  o_any_c : at least one request present
//  o_idx_c : first requesting index at or after i_ptr, wrapping
module rot_sched_rr_arbiter
    import rot_sched_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IDXW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_any_c,
    output logic [IDXW-1:0] o_idx_c
);

    logic        w_found;
    int unsigned w_cand;

    assign o_any_c = |i_req;

    // Scan NREQ positions starting at the pointer; first hit wins.
    always_comb begin
        o_idx_c = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = (32'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_cand]) begin
                o_idx_c = IDXW'(w_cand);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rot_sched.sv
// Round-robin scheduler for the shared mux -> rotator -> demux datapath.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : rot_sched_if slave port
//    in : req (held until gnt), rot_amt (slice i for requester i)
//    out: gnt, mux_sel, rotation, issue_valid   (issue side)
//         demux_sel, demux_valid                (return side)
//         busy                                  (state != IDLE)
// One op at a time: ISSUE (1) -> WAIT (LAT) -> RETURN (1); RETURN may
// chain straight into the next ISSUE. All outputs are registered.
module rot_sched
    import rot_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned RW   = RW_DEF,
    parameter int unsigned LAT  = LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    rot_sched_if.slave  bus
);

    localparam int unsigned IDXW = idx_w(NREQ);
    localparam int unsigned CW   = idx_w(LAT);

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [IDXW-1:0] r_win, w_win_nxt;

    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDXW-1:0] r_mux_sel, w_mux_sel_nxt;
    logic [RW-1:0]   r_rotation, w_rotation_nxt;
    logic            r_issue_valid, w_issue_valid_nxt;
    logic [IDXW-1:0] r_demux_sel, w_demux_sel_nxt;
    logic            r_demux_valid, w_demux_valid_nxt;
    logic            r_busy, w_busy_nxt;

    logic            w_any;
    logic [IDXW-1:0] w_idx;

    rot_sched_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_any_c (w_any),
        .o_idx_c (w_idx)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_win         <= '0;
            r_gnt         <= '0;
            r_mux_sel     <= '0;
            r_rotation    <= '0;
            r_issue_valid <= 1'b0;
            r_demux_sel   <= '0;
            r_demux_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_win         <= w_win_nxt;
            r_gnt         <= w_gnt_nxt;
            r_mux_sel     <= w_mux_sel_nxt;
            r_rotation    <= w_rotation_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_demux_sel   <= w_demux_sel_nxt;
            r_demux_valid <= w_demux_valid_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic. An issue is launched from IDLE or
    // RETURN; the winner's rotation slice is captured here and only here.
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_win_nxt         = r_win;
        w_gnt_nxt         = '0;
        w_mux_sel_nxt     = r_mux_sel;
        w_rotation_nxt    = r_rotation;
        w_issue_valid_nxt = 1'b0;
        w_demux_sel_nxt   = r_demux_sel;
        w_demux_valid_nxt = 1'b0;

        unique case (r_state)
            S_IDLE, S_RETURN: begin
                if (w_any) begin
                    w_state_nxt       = S_ISSUE;
                    w_win_nxt         = w_idx;
                    w_gnt_nxt         = NREQ'(1) << w_idx;
                    w_mux_sel_nxt     = w_idx;
                    w_rotation_nxt    = bus.rot_amt[32'(w_idx) * RW +: RW];
                    w_issue_valid_nxt = 1'b1;
                    w_cnt_nxt         = CW'(LAT - 1);
                    // Winner drops to lowest priority for the next round.
                    w_ptr_nxt         = (w_idx == IDXW'(NREQ - 1)) ? '0 : w_idx + IDXW'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt       = S_RETURN;
                    w_demux_sel_nxt   = r_win;
                    w_demux_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.gnt         = r_gnt;
    assign bus.mux_sel     = r_mux_sel;
    assign bus.rotation    = r_rotation;
    assign bus.issue_valid = r_issue_valid;
    assign bus.demux_sel   = r_demux_sel;
    assign bus.demux_valid = r_demux_valid;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rot_sched.sv
// Self-checking bench for rot_sched (NREQ=4, RW=3, LAT=2).
// Expected ops are queued when requests are driven; a negedge monitor pops
// them on issue_valid and again on demux_valid.
module tb_rot_sched;
    import rot_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned RW   = 3;
    localparam int unsigned LAT  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rot_sched_if #(.NREQ(NREQ), .RW(RW)) bus ();

    rot_sched #(.NREQ(NREQ), .RW(RW), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned    idx;
        logic [RW-1:0]  rot;
        int unsigned    gap;   // required issue-to-issue spacing, 0 = unchecked
    } exp_t;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*RW-1:0] rot;
        int unsigned        exp_w;
    } vec_t;

    exp_t        iss_q[$];
    exp_t        dmx_q[$];
    int unsigned dmx_due_q[$];
    exp_t        m_e;
    int unsigned m_due;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned last_iss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned idx, input logic [NREQ*RW-1:0] rot,
                            input int unsigned gap);
        exp_t e;
        e.idx = idx;
        e.rot = rot[idx*RW +: RW];
        e.gap = gap;
        iss_q.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.issue_valid) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    m_e = iss_q.pop_front();
                    chk("gnt", 32'(bus.gnt), 32'(1) << m_e.idx);
                    chk("mux_sel", 32'(bus.mux_sel), m_e.idx);
                    chk("rotation", 32'(bus.rotation), 32'(m_e.rot));
                    if (m_e.gap != 0) chk("issue_gap", cyc - last_iss, m_e.gap);
                    dmx_q.push_back(m_e);
                    dmx_due_q.push_back(cyc + LAT + 1);
                end
                last_iss = cyc;
            end else begin
                chk("gnt_idle", 32'(bus.gnt), 0);
            end
            if (bus.demux_valid) begin
                if (dmx_q.size() == 0) begin
                    chk("unexpected_demux", 1, 0);
                end else begin
                    m_e   = dmx_q.pop_front();
                    m_due = dmx_due_q.pop_front();
                    chk("demux_sel", 32'(bus.demux_sel), m_e.idx);
                    chk("demux_time", cyc, m_due);
                    chk("rotation_hold", 32'(bus.rotation), 32'(m_e.rot));
                    chk("mux_sel_hold", 32'(bus.mux_sel), m_e.idx);
                end
            end
        end
    end

    task automatic wait_issue(input string nm, output int unsigned lat);
        int unsigned n = 0;
        @(negedge clk);
        while (!bus.issue_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.issue_valid) chk({nm, "_issue_timeout"}, 1, 0);
        lat = n;
    endtask

    task automatic wait_idle(input string nm);
        int unsigned n = 0;
        while ((bus.busy || iss_q.size() != 0 || dmx_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_busy"}, 32'(bus.busy), 0);
        chk({nm, "_idle_pending"}, iss_q.size() + dmx_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"}, 32'(bus.gnt), 0);
        chk({nm, "_mux_sel"}, 32'(bus.mux_sel), 0);
        chk({nm, "_rotation"}, 32'(bus.rotation), 0);
        chk({nm, "_issue_valid"}, 32'(bus.issue_valid), 0);
        chk({nm, "_demux_sel"}, 32'(bus.demux_sel), 0);
        chk({nm, "_demux_valid"}, 32'(bus.demux_valid), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t               vt[7];
    int unsigned        lat;
    int unsigned        n;
    int unsigned        issues;
    logic [NREQ*RW-1:0] rot;

    initial begin
        // ptr sequence: 1 after test 1, then each row advances it past its winner.
        vt[0] = '{4'b0100, {3'd2, 3'd5, 3'd6, 3'd4}, 2};
        vt[1] = '{4'b1001, {3'd7, 3'd1, 3'd2, 3'd3}, 3};
        vt[2] = '{4'b1010, {3'd0, 3'd4, 3'd6, 3'd1}, 1};
        vt[3] = '{4'b0001, {3'd5, 3'd5, 3'd5, 3'd6}, 0};
        vt[4] = '{4'b1101, {3'd1, 3'd7, 3'd3, 3'd2}, 2};
        vt[5] = '{4'b0110, {3'd4, 3'd0, 3'd2, 3'd7}, 1};
        vt[6] = '{4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 2};

        // Reset with all requests asserted.
        rst_n       = 1'b0;
        bus.req     = '1;
        bus.rot_amt = {3'd7, 3'd5, 3'd3, 3'd1};
        repeat (3) @(negedge clk);
        chk_all_zero("t1_reset");
        push_exp(0, bus.rot_amt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        wait_idle("t1");

        // Table of isolated ops.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.req     = vt[i].req;
            bus.rot_amt = vt[i].rot;
            push_exp(vt[i].exp_w, vt[i].rot, 0);
            wait_issue("vec", lat);
            chk("vec_req_to_issue", lat, 0);
            bus.req = '0;
            wait_idle("vec");
        end

        // ptr=3, requests 0 and 1: wraps to 0, then 1 back-to-back, 3 never.
        @(negedge clk);
        rot         = {3'd6, 3'd1, 3'd4, 3'd2};
        bus.rot_amt = rot;
        bus.req     = 4'b0011;
        push_exp(0, rot, 0);
        push_exp(1, rot, LAT + 2);
        n = 0;
        while (bus.req != '0 && n < 40) begin
            @(negedge clk);
            if (bus.issue_valid) bus.req = bus.req & ~bus.gnt;
            n++;
        end
        chk("t4_drain_timeout", 32'(n >= 40), 0);
        wait_idle("t4");

        // rot_amt and req change while the op is in WAIT.
        @(negedge clk);
        rot         = {3'd0, 3'd0, 3'd3, 3'd0};
        bus.rot_amt = rot;
        bus.req     = 4'b0010;
        push_exp(1, rot, 0);
        wait_issue("t5", lat);
        @(negedge clk);
        bus.rot_amt[5:3] = 3'd6;
        bus.req          = '0;
        @(negedge clk);
        chk("t5_rot_in_wait", 32'(bus.rotation), 3);
        wait_idle("t5");

        // Reset during WAIT discards the op.
        @(negedge clk);
        bus.req = 4'b1000;
        push_exp(3, bus.rot_amt, 0);
        wait_issue("t6", lat);
        bus.req = '0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_reset");
        iss_q.delete();
        dmx_q.delete();
        dmx_due_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_stay_idle", 32'(bus.busy), 0);
        chk("t6_no_demux", 32'(bus.demux_valid), 0);

        // Fairness with all requests held after reset: 0,1,2,3,0.
        @(negedge clk);
        rot         = {3'd1, 3'd2, 3'd3, 3'd4};
        bus.rot_amt = rot;
        bus.req     = '1;
        push_exp(0, rot, 0);
        push_exp(1, rot, LAT + 2);
        push_exp(2, rot, LAT + 2);
        push_exp(3, rot, LAT + 2);
        push_exp(0, rot, LAT + 2);
        issues = 0;
        n      = 0;
        while (issues < 5 && n < 60) begin
            @(negedge clk);
            if (bus.issue_valid) issues++;
            n++;
        end
        chk("t3_issue_count", issues, 5);
        bus.req = '0;
        wait_idle("t3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
